alp_request_arbiter: RTL and testbench
======================================

Name: alp_request_arbiter

Overview:
- Shares the single 8-bit ALP datapath and its controller between two independent requesters.
- Accepts operation requests over valid/ready channels and arbitrates them round-robin.
- Issues one COMP pulse per operation, waits for completion with a timeout, and returns R0/R1/ERR on per-requester response channels.
- At most one operation in flight. Sits between the host/test logic and the ALP controller.

Parameters:
WIDTH, 8, operand/result width
TIMEOUT, 64, max WAIT cycles before abort (must be ≥ 2)
DIV_OP, 3'b011, opcode treated as divide (divide-by-zero check)

Ports:
clk  in  1  clock, rising edge
CLR_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 request valid
req0_ready  out  1  requester 0 request accepted
req0_op  in  3  ALP opcode
req0_a  in  WIDTH  operand A (dividend for DIV)
req0_b  in  WIDTH  operand B (divisor for DIV)
req1_valid/req1_ready/req1_op/req1_a/req1_b  as above, requester 1
rsp0_valid  out  1  response valid, requester 0
rsp0_ready  in  1  response accepted
rsp0_res  out  WIDTH  captured R0
rsp0_ext  out  WIDTH  captured R1 (high byte/remainder)
rsp0_err  out  1  datapath ERR, or divide-by-zero
rsp0_tout  out  1  operation aborted by timeout
rsp1_valid/rsp1_ready/rsp1_res/rsp1_ext/rsp1_err/rsp1_tout  as above, requester 1
dp_comp  out  1  one-cycle start pulse to ALP controller
dp_op  out  3  opcode to controller
dp_a  out  WIDTH  operand A to datapath
dp_b  out  WIDTH  operand B to datapath
dp_clr  out  1  datapath clear (active high)
dp_done  in  1  controller reached end state
dp_err  in  1  controller ERR
dp_r0  in  WIDTH  R0 output
dp_r1  in  WIDTH  R1 output

Behaviour:
- Reset (CLR_n low at clk edge): state IDLE; all outputs 0; rr pointer = 1, so requester 0 wins the first tie. Reset mid-operation drops the in-flight op and any pending response; no dp_clr is generated.
- FSM states: IDLE, ISSUE, WAIT, ABORT, DIVZ, RESP.
- IDLE:
  - reqN_ready is combinational: high only for the granted requester while in IDLE.
  - Grant: if only one valid, that requester; if both valid, the one not equal to the rr pointer (last served).
  - On valid&&ready, latch op/a/b and owner.
  - If op==DIV_OP and b==0, go to DIVZ; otherwise go to ISSUE.
- ISSUE: dp_comp=1 for exactly this cycle. dp_op/dp_a/dp_b hold the latched values from ISSUE through RESP exit. Clear the wait counter. Next state: WAIT.
- WAIT:
  - Counter increments each cycle.
  - dp_done=1: capture dp_r0→res, dp_r1→ext, dp_err→err, tout=0; go to RESP. dp_done is ignored in every other state.
  - Counter == TIMEOUT-1 with no done: res=ext=0, err=0, tout=1; go to ABORT. If done and timeout coincide, done wins.
- ABORT: dp_clr=1 for 2 consecutive cycles, then RESP.
- DIVZ: no datapath activity; res=ext=0, err=1, tout=0; go to RESP after 1 cycle.
- RESP:
  - rspN_valid=1 for the owner only; res/ext/err/tout stay stable while valid.
  - Hold until rspN_ready. On the handshake: rr pointer = owner, rsp valid drops next cycle, return to IDLE. No new request is accepted in this cycle.
- Latency from request accept to rsp_valid:
  - normal: 2 + (cycles to dp_done)
  - DIVZ: 2
  - timeout: TIMEOUT + 3
- All outputs except reqN_ready are registered.

Test Plan:
- req0 op=000 a=8'd20 b=8'd22; dp model asserts dp_done 3 cycles after dp_comp with r0=42 → one-cycle dp_comp with dp_a=20, dp_b=22; rsp0_valid with res=42, err=0, tout=0; rsp1_valid stays 0.
- req0 and req1 valid in the same cycle after reset, then again after completion → first grant req0, second grant req1; exactly one dp_comp per op.
- req1 op=011 a=8'd100 b=0 → no dp_comp; rsp1_valid 2 cycles after accept with err=1, res=0.
- dp_done never asserted with TIMEOUT=64 → rsp_tout=1 at accept+67 cycles; dp_clr high exactly 2 cycles; next request is serviced normally.
- rsp0_ready held low for 10 cycles while req1 is valid → rsp0 fields stay stable, req1_ready stays 0; req1 is accepted the cycle after the handshake completes.
- CLR_n low during WAIT → all outputs 0 next cycle; a later dp_done is ignored; the next req0 is accepted from IDLE.

Source files
------------

// File: rtl/alp_request_arbiter_if.sv
// alp_request_arbiter_if: request/response channels and ALP datapath link of the arbiter
interface alp_request_arbiter_if #(parameter int WIDTH = 8);
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]       req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             rsp0_valid, rsp0_ready, rsp0_err, rsp0_tout;
  logic             rsp1_valid, rsp1_ready, rsp1_err, rsp1_tout;
  logic [WIDTH-1:0] rsp0_res, rsp0_ext, rsp1_res, rsp1_ext;
  logic             dp_comp, dp_clr, dp_done, dp_err;
  logic [2:0]       dp_op;
  logic [WIDTH-1:0] dp_a, dp_b, dp_r0, dp_r1;
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    input  rsp0_ready, rsp1_ready,
    output rsp0_valid, rsp0_res, rsp0_ext, rsp0_err, rsp0_tout,
    output rsp1_valid, rsp1_res, rsp1_ext, rsp1_err, rsp1_tout,
    output dp_comp, dp_op, dp_a, dp_b, dp_clr,
    input  dp_done, dp_err, dp_r0, dp_r1
  );
  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    output rsp0_ready, rsp1_ready,
    input  rsp0_valid, rsp0_res, rsp0_ext, rsp0_err, rsp0_tout,
    input  rsp1_valid, rsp1_res, rsp1_ext, rsp1_err, rsp1_tout,
    input  dp_comp, dp_op, dp_a, dp_b, dp_clr,
    output dp_done, dp_err, dp_r0, dp_r1
  );
endinterface

// File: rtl/alp_request_arbiter.sv
// alp_request_arbiter: round-robin sharing of one ALP datapath between two requesters
module alp_request_arbiter #(
  parameter int         WIDTH   = 8,
  parameter int         TIMEOUT = 64,
  parameter logic [2:0] DIV_OP  = 3'b011
) (
  input logic clk,
  input logic CLR_n,
  alp_request_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ABORT, DIVZ, RESP} state_t;
  state_t           r_state, w_next;
  logic             r_rr, r_own, r_ab, r_err, r_tout, r_comp, r_clr, r_v0, r_v1;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op, w_op;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_ext, w_a, w_b;
  logic             w_g0, w_g1, w_acc, w_hs, w_tmo, w_comp, w_clr, w_v0, w_v1;
  // tie goes to the requester that was not served last
  assign w_g1  = bus.req1_valid && (!bus.req0_valid || !r_rr);
  assign w_g0  = bus.req0_valid && !w_g1;
  assign w_acc = (r_state == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign w_op  = w_g1 ? bus.req1_op : bus.req0_op;
  assign w_a   = w_g1 ? bus.req1_a : bus.req0_a;
  assign w_b   = w_g1 ? bus.req1_b : bus.req0_b;
  assign w_hs  = (r_state == RESP) && (r_own ? bus.rsp1_ready : bus.rsp0_ready);
  assign w_tmo = r_cnt == CW'(TIMEOUT - 1);
  assign bus.req0_ready = (r_state == IDLE) && w_g0;
  assign bus.req1_ready = (r_state == IDLE) && w_g1;
  assign bus.dp_comp = r_comp;
  assign bus.dp_clr  = r_clr;
  assign bus.dp_op   = r_op;
  assign bus.dp_a    = r_a;
  assign bus.dp_b    = r_b;
  assign bus.rsp0_valid = r_v0;
  assign bus.rsp1_valid = r_v1;
  assign bus.rsp0_res  = r_res;
  assign bus.rsp1_res  = r_res;
  assign bus.rsp0_ext  = r_ext;
  assign bus.rsp1_ext  = r_ext;
  assign bus.rsp0_err  = r_err;
  assign bus.rsp1_err  = r_err;
  assign bus.rsp0_tout = r_tout;
  assign bus.rsp1_tout = r_tout;
  // state register plus operation context, wait/abort counters and captured result
  always_ff @(posedge clk) begin
    if (!CLR_n) begin
      r_state <= IDLE;
      r_rr    <= 1'b1;
      r_own   <= 1'b0;
      r_ab    <= 1'b0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_ext   <= '0;
      r_err   <= 1'b0;
      r_tout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_own <= w_g1;
        r_op  <= w_op;
        r_a   <= w_a;
        r_b   <= w_b;
      end
      r_cnt <= (w_next == ISSUE) ? '0 : r_cnt + 1'b1;
      r_ab  <= (r_state == ABORT) && !r_ab;
      if (w_hs) r_rr <= r_own;
      if (r_state == WAIT && bus.dp_done) begin
        r_res  <= bus.dp_r0;
        r_ext  <= bus.dp_r1;
        r_err  <= bus.dp_err;
        r_tout <= 1'b0;
      end else if ((r_state == WAIT && w_tmo) || r_state == DIVZ) begin
        r_res  <= '0;
        r_ext  <= '0;
        r_err  <= r_state == DIVZ;
        r_tout <= r_state == WAIT;
      end
    end
  end
  // next-state: done beats a coincident timeout; handshake cycle never accepts
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_next = (w_op == DIV_OP && w_b == '0) ? DIVZ : ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (bus.dp_done || w_tmo) w_next = bus.dp_done ? RESP : ABORT;
      ABORT:   if (r_ab) w_next = RESP;
      DIVZ:    w_next = RESP;
      RESP:    if (w_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // outputs derived from the upcoming state so they register in step with it
  always_comb begin
    w_comp = w_next == ISSUE;
    w_clr  = w_next == ABORT;
    w_v0   = w_next == RESP && !r_own;
    w_v1   = w_next == RESP && r_own;
  end
  // registered strobes and response valids
  always_ff @(posedge clk) begin
    if (!CLR_n) begin
      r_comp <= 1'b0;
      r_clr  <= 1'b0;
      r_v0   <= 1'b0;
      r_v1   <= 1'b0;
    end else begin
      r_comp <= w_comp;
      r_clr  <= w_clr;
      r_v0   <= w_v0;
      r_v1   <= w_v1;
    end
  end
endmodule

// File: tb/tb_alp_request_arbiter.sv
// tb_alp_request_arbiter: table, directed and randomized checks of the request arbiter
module tb_alp_request_arbiter;
  localparam int TOUT = 64;
  logic clk = 1'b0;
  logic CLR_n = 1'b0;
  int checks = 0, failures = 0;
  int n_comp = 0, n_clr = 0, pend = 0, dp_delay = 0;
  alp_request_arbiter_if #(.WIDTH(8)) bus ();
  alp_request_arbiter #(.WIDTH(8), .TIMEOUT(TOUT), .DIV_OP(3'b011)) dut (.clk(clk), .CLR_n(CLR_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [7:0] f_r0(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    return (op == 3'd0) ? a + b : a ^ b;
  endfunction
  function automatic logic [7:0] f_r1(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (op == 3'd0) ? {7'd0, s[8]} : (a & b);
  endfunction

  // ALP datapath stand-in: done pulses dp_delay cycles after comp, 0 means never
  assign bus.dp_done = pend == 1;
  assign bus.dp_r0   = f_r0(bus.dp_op, bus.dp_a, bus.dp_b);
  assign bus.dp_r1   = f_r1(bus.dp_op, bus.dp_a, bus.dp_b);
  assign bus.dp_err  = bus.dp_op == 3'd7;
  always @(posedge clk) begin
    if (bus.dp_comp) pend <= dp_delay;
    else if (pend > 0) pend <= pend - 1;
    if (bus.dp_comp) n_comp <= n_comp + 1;
    if (bus.dp_clr) n_clr <= n_clr + 1;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp0_ready = 0; bus.rsp1_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    CLR_n = 0;
    @(negedge clk);
    @(negedge clk);
    CLR_n = 1;
  endtask

  task automatic do_txn(input string nm, input logic v0, input logic v1,
                        input logic [2:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic [2:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                        input int d, input int hold, input logic own, input int lat_e,
                        input logic [7:0] res_e, input logic [7:0] ext_e, input logic err_e,
                        input logic tout_e, input int comp_e, input int clr_e);
    int lat, c0, k0;
    dp_delay = d;
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
    #1;
    chk({nm, " ready0"}, bus.req0_ready, !own);
    chk({nm, " ready1"}, bus.req1_ready, own);
    c0 = n_comp;
    k0 = n_clr;
    @(negedge clk);
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    lat = 1;
    while (!bus.rsp0_valid && !bus.rsp1_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, lat_e);
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge clk);
      chk({nm, " rsp0_valid"}, bus.rsp0_valid, !own);
      chk({nm, " rsp1_valid"}, bus.rsp1_valid, own);
      chk({nm, " res"}, own ? bus.rsp1_res : bus.rsp0_res, res_e);
      chk({nm, " ext"}, own ? bus.rsp1_ext : bus.rsp0_ext, ext_e);
      chk({nm, " err"}, own ? bus.rsp1_err : bus.rsp0_err, err_e);
      chk({nm, " tout"}, own ? bus.rsp1_tout : bus.rsp0_tout, tout_e);
      if (comp_e != 0) begin
        chk({nm, " dp_op"}, bus.dp_op, own ? op1 : op0);
        chk({nm, " dp_a"}, bus.dp_a, own ? a1 : a0);
        chk({nm, " dp_b"}, bus.dp_b, own ? b1 : b0);
      end
    end
    if (own) bus.rsp1_ready = 1; else bus.rsp0_ready = 1;
    @(negedge clk);
    bus.rsp0_ready = 0;
    bus.rsp1_ready = 0;
    chk({nm, " valid drop"}, {bus.rsp0_valid, bus.rsp1_valid}, 0);
    chk({nm, " comp count"}, n_comp - c0, comp_e);
    chk({nm, " clr count"}, n_clr - k0, clr_e);
  endtask

  typedef struct {
    logic v0, v1;
    logic [2:0] op0; logic [7:0] a0, b0;
    logic [2:0] op1; logic [7:0] a1, b1;
    int d, hold;
    logic own; int lat;
    logic [7:0] res, ext; logic err, tout;
    int comp, clr;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic m_last, v0, v1, own, divz;
    logic [2:0] op0, op1, op;
    logic [7:0] a0, b0, a1, b1, a, b;
    int d, c0;
    tbl[0] = '{1, 1, 3'd0, 8'd20, 8'd22, 3'd1, 8'd9, 8'd9, 3, 2, 0, 5, 8'd42, 8'd0, 0, 0, 1, 0};
    tbl[1] = '{1, 1, 3'd0, 8'd5, 8'd5, 3'd2, 8'h0F, 8'h3C, 1, 0, 1, 3, 8'h33, 8'h0C, 0, 0, 1, 0};
    tbl[2] = '{0, 1, 3'd0, 8'd0, 8'd0, 3'd3, 8'd100, 8'd0, 3, 1, 1, 2, 8'd0, 8'd0, 1, 0, 0, 0};
    tbl[3] = '{1, 0, 3'd7, 8'h80, 8'h80, 3'd0, 8'd0, 8'd0, 2, 0, 0, 4, 8'h00, 8'h80, 1, 0, 1, 0};
    tbl[4] = '{1, 0, 3'd3, 8'd200, 8'd7, 3'd0, 8'd0, 8'd0, 4, 0, 0, 6, 8'hCF, 8'h00, 0, 0, 1, 0};
    tbl[5] = '{0, 1, 3'd0, 8'd0, 8'd0, 3'd1, 8'd5, 8'd6, 0, 1, 1, TOUT + 3, 8'd0, 8'd0, 0, 1, 1, 2};
    tbl[6] = '{1, 1, 3'd0, 8'hFF, 8'h01, 3'd0, 8'd3, 8'd3, 2, 0, 0, 4, 8'h00, 8'h01, 0, 0, 1, 0};
    tbl[7] = '{1, 0, 3'd0, 8'd10, 8'd20, 3'd0, 8'd0, 8'd0, TOUT - 1, 0, 0, TOUT + 1, 8'd30, 8'd0, 0, 0, 1, 0};
    tbl[8] = '{0, 1, 3'd0, 8'd0, 8'd0, 3'd0, 8'd1, 8'd1, TOUT, 0, 1, TOUT + 3, 8'd0, 8'd0, 0, 1, 1, 2};
    tbl[9] = '{0, 1, 3'd0, 8'd0, 8'd0, 3'd0, 8'd7, 8'd8, TOUT - 2, 0, 1, TOUT, 8'd15, 8'd0, 0, 0, 1, 0};
    idle_inputs();
    bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    do_reset();
    @(negedge clk);
    chk("reset rsp valids", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    chk("reset dp strobes", {bus.dp_comp, bus.dp_clr}, 0);
    chk("reset dp bus", {bus.dp_op, bus.dp_a, bus.dp_b}, 0);
    chk("reset rsp0 fields", {bus.rsp0_res, bus.rsp0_ext, bus.rsp0_err, bus.rsp0_tout}, 0);
    chk("reset rsp1 fields", {bus.rsp1_res, bus.rsp1_ext, bus.rsp1_err, bus.rsp1_tout}, 0);
    chk("reset readies", {bus.req0_ready, bus.req1_ready}, 0);
    for (int i = 0; i < 10; i++)
      do_txn($sformatf("vec%0d", i), tbl[i].v0, tbl[i].v1, tbl[i].op0, tbl[i].a0, tbl[i].b0,
             tbl[i].op1, tbl[i].a1, tbl[i].b1, tbl[i].d, tbl[i].hold, tbl[i].own, tbl[i].lat,
             tbl[i].res, tbl[i].ext, tbl[i].err, tbl[i].tout, tbl[i].comp, tbl[i].clr);
    // response backpressure with the other requester waiting
    dp_delay = 2;
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_op = 0; bus.req0_a = 9; bus.req0_b = 8;
    #1;
    chk("bp accept0", bus.req0_ready, 1);
    @(negedge clk);
    bus.req0_valid = 0;
    lat = 1;
    while (!bus.rsp0_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("bp latency0", lat, 4);
    bus.req1_valid = 1; bus.req1_op = 0; bus.req1_a = 50; bus.req1_b = 60;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("bp hold valid", bus.rsp0_valid, 1);
      chk("bp hold res", bus.rsp0_res, 17);
      chk("bp req1_ready low", bus.req1_ready, 0);
    end
    @(negedge clk);
    bus.rsp0_ready = 1;
    #1;
    chk("bp no accept at handshake", bus.req1_ready, 0);
    @(negedge clk);
    bus.rsp0_ready = 0;
    #1;
    chk("bp rsp0 dropped", bus.rsp0_valid, 0);
    chk("bp req1 accepted next", bus.req1_ready, 1);
    @(negedge clk);
    bus.req1_valid = 0;
    lat = 1;
    while (!bus.rsp1_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("bp latency1", lat, 4);
    chk("bp res1", bus.rsp1_res, 110);
    bus.rsp1_ready = 1;
    @(negedge clk);
    bus.rsp1_ready = 0;
    // reset while waiting for the datapath
    dp_delay = 5;
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_op = 0; bus.req0_a = 1; bus.req0_b = 2;
    @(negedge clk);
    bus.req0_valid = 0;
    @(negedge clk);
    @(negedge clk);
    CLR_n = 0;
    @(negedge clk);
    CLR_n = 1;
    chk("midrst outputs", {bus.rsp0_valid, bus.rsp1_valid, bus.dp_comp, bus.dp_clr, bus.dp_a, bus.rsp0_res}, 0);
    c0 = n_comp;
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("midrst done ignored", {bus.rsp0_valid, bus.rsp1_valid, bus.dp_clr}, 0);
    chk("midrst no comp", n_comp - c0, 0);
    do_txn("midrst next", 1, 0, 3'd0, 8'd3, 8'd4, 3'd0, 8'd0, 8'd0, 1, 0, 0, 3, 8'd7, 8'd0, 0, 0, 1, 0);
    // randomized traffic against a transaction-level model
    do_reset();
    m_last = 1;
    for (int n = 0; n < 40; n++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      op0 = 3'($urandom_range(0, 7)); a0 = 8'($urandom); b0 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      op1 = 3'($urandom_range(0, 7)); a1 = 8'($urandom); b1 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      d = ($urandom_range(0, 14) == 0) ? 0 : int'($urandom_range(1, 8));
      own = (v0 && v1) ? !m_last : v1;
      op = own ? op1 : op0;
      a = own ? a1 : a0;
      b = own ? b1 : b0;
      divz = op == 3'b011 && b == 0;
      if (divz)
        do_txn($sformatf("rnd%0d", n), v0, v1, op0, a0, b0, op1, a1, b1, d, int'($urandom_range(0, 3)),
               own, 2, 8'd0, 8'd0, 1, 0, 0, 0);
      else if (d == 0)
        do_txn($sformatf("rnd%0d", n), v0, v1, op0, a0, b0, op1, a1, b1, d, int'($urandom_range(0, 3)),
               own, TOUT + 3, 8'd0, 8'd0, 0, 1, 1, 2);
      else
        do_txn($sformatf("rnd%0d", n), v0, v1, op0, a0, b0, op1, a1, b1, d, int'($urandom_range(0, 3)),
               own, 2 + d, f_r0(op, a, b), f_r1(op, a, b), op == 3'd7, 0, 1, 0);
      m_last = own;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
